// File: rtl/ecap5_dproc_pkg.sv
// Shared types for the data-side Wishbone memory responder.
// Imported by the responder FSM and its backing RAM.
package ecap5_dproc_pkg;

    localparam int WB_SEL_WIDTH  = 4;
    localparam int WB_DATA_WIDTH = 32;
    localparam int WB_WAIT_BITS  = 4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        ACCESS = 3'd2,
        ACK    = 3'd3
    } wb_slave_state_t;

    typedef struct packed {
        logic                     we;
        logic                     hit;
        logic [WB_SEL_WIDTH-1:0]  sel;
        logic [WB_DATA_WIDTH-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/sram_sp.sv
// Single-port synchronous word RAM with byte write enables
// and a one-cycle registered read port.
module sram_sp
    import ecap5_dproc_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                     clk_i,
    input  logic                     rd_en,
    input  logic [WB_SEL_WIDTH-1:0]  wr_be,
    input  logic [ADDR_WIDTH-1:0]    addr,
    input  logic [WB_DATA_WIDTH-1:0] wdata,
    output logic [WB_DATA_WIDTH-1:0] rdata
);

    logic [WB_DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < WB_SEL_WIDTH; i++) begin
            if (wr_be[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wb_mem_slave.sv
// Pipelined Wishbone B4 memory responder with optional
// wait states; one outstanding request at a time.
module wb_mem_slave
    import ecap5_dproc_pkg::*;
#(
    parameter int          ADDR_WIDTH  = 10,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic [31:0]              wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0] wb_dat_i,
    output logic [WB_DATA_WIDTH-1:0] wb_dat_o,
    input  logic                     wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  wb_sel_i,
    input  logic                     wb_stb_i,
    input  logic                     wb_cyc_i,
    output logic                     wb_ack_o,
    output logic                     wb_stall_o
);

    localparam logic [32:0] SPAN = 33'(1) << (ADDR_WIDTH + 2);
    localparam logic [WB_WAIT_BITS-1:0] CNT_LOAD =
        WB_WAIT_BITS'(WAIT_CYCLES > 0 ? WAIT_CYCLES - 1 : 0);

    wb_slave_state_t         state;
    logic [WB_WAIT_BITS-1:0] cnt;
    logic                    stall_q;
    logic                    ack_q;

    wb_req_t                 req;
    logic [ADDR_WIDTH-1:0]   req_idx;

    logic [31:0]             offset;
    logic                    hit;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    accept;

    logic                     ram_rd;
    logic [WB_SEL_WIDTH-1:0]  ram_be;
    logic [WB_DATA_WIDTH-1:0] ram_q;

    // Offsets below BASE_ADDR wrap to large values and miss.
    assign offset = wb_adr_i - BASE_ADDR;
    assign hit    = {1'b0, offset} < SPAN;
    assign idx    = offset[ADDR_WIDTH+1:2];
    assign accept = wb_cyc_i & wb_stb_i & ~stall_q;

    always_ff @(posedge clk_i) begin
        if (accept) begin
            req.we  <= wb_we_i;
            req.hit <= hit;
            req.sel <= wb_sel_i;
            req.dat <= wb_dat_i;
            req_idx <= idx;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state   <= IDLE;
            cnt     <= '0;
            stall_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    ack_q <= 1'b0;
                    if (accept) begin
                        stall_q <= 1'b1;
                        if (WAIT_CYCLES > 0) begin
                            state <= WAIT;
                            cnt   <= CNT_LOAD;
                        end else begin
                            state <= ACCESS;
                        end
                    end
                end
                WAIT: begin
                    if (!wb_cyc_i) begin
                        state   <= IDLE;
                        stall_q <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= ACCESS;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACCESS: begin
                    if (wb_cyc_i) begin
                        state <= ACK;
                        ack_q <= 1'b1;
                    end else begin
                        state   <= IDLE;
                        stall_q <= 1'b0;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    ack_q   <= 1'b0;
                    stall_q <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    ack_q   <= 1'b0;
                    stall_q <= 1'b0;
                end
            endcase
        end
    end

    // Write lanes close with ACCESS unless aborted or reset.
    always_comb begin
        ram_rd = 1'b0;
        ram_be = '0;
        if (state == ACCESS && req.hit) begin
            ram_rd = ~req.we;
            if (req.we && wb_cyc_i && rst_ni) begin
                ram_be = req.sel;
            end
        end
    end

    sram_sp #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .clk_i(clk_i),
        .rd_en(ram_rd),
        .wr_be(ram_be),
        .addr (req_idx),
        .wdata(req.dat),
        .rdata(ram_q)
    );

    assign wb_stall_o = stall_q;
    assign wb_ack_o   = ack_q;
    assign wb_dat_o   = (ack_q && !req.we && req.hit) ? ram_q : '0;

endmodule
